// File: rtl/arbiter.sv
// Central bus arbiter: decodes the serial frames from each master, grants the bus by
// fixed priority, preempts/splits transactions and reports the owner on bus_state.
module arbiter #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             port_in  [0:NO_MASTERS-1],
  output logic                             port_out [0:NO_MASTERS-1],
  input  logic                             ready,
  output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state
);

  // state        | meaning
  // IDLE         | no activity, waiting for the first REQUEST bit
  // RX_REQ       | receiving REQUEST frame (1,1,1,slave id)
  // PENDING      | valid request recorded, waiting for arbitration
  // GRANTED      | GRANT sent, waiting for START (1,0,1)
  // COMM         | owns the bus, line held 1
  // PREEMPTED    | owns the bus, PREEMPT sent, waiting for HOLD or END
  // HELD         | split transaction parked, slave id kept, re-queued
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_REQ,
    ST_PENDING,
    ST_GRANTED,
    ST_COMM,
    ST_PREEMPTED,
    ST_HELD
  } mst_state_e;

  localparam int              CW            = $clog2(S_ID_WIDTH + 4);
  localparam logic [CW-1:0]   REQ_LAST      = CW'(2 + S_ID_WIDTH);
  localparam logic [CW-1:0]   REQ_SID_FIRST = CW'(3);
  localparam logic [2:0]      FRAME_GRANT   = 3'b110;
  localparam logic [2:0]      FRAME_PREEMPT = 3'b101;

  mst_state_e                  state_q [NO_MASTERS];
  mst_state_e                  state_d [NO_MASTERS];
  logic [CW-1:0]               cnt_q   [NO_MASTERS];
  logic [CW-1:0]               cnt_d   [NO_MASTERS];
  logic                        rx_q    [NO_MASTERS];
  logic                        rx_d    [NO_MASTERS];
  logic [S_ID_WIDTH-1:0]       sid_q   [NO_MASTERS];
  logic [S_ID_WIDTH-1:0]       sid_d   [NO_MASTERS];
  logic [1:0]                  tx_q    [NO_MASTERS];
  logic [1:0]                  tx_d    [NO_MASTERS];
  logic                        po_q    [NO_MASTERS];
  logic                        po_d    [NO_MASTERS];
  logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_q, bus_d;

  logic                  bus_busy;
  logic [M_ID_WIDTH-1:0] owner_idx;
  logic                  any_pend, any_held, hi_pend, other_wait;
  logic [M_ID_WIDTH-1:0] pend_idx, held_idx, grant_idx;
  logic                  grant_vld, preempt_vld;
  logic [S_ID_WIDTH-1:0] sid_nx;

  // Pending masters are served before held ones so a split actually lets the waiter in.
  always_comb begin
    bus_busy   = 1'b0;
    owner_idx  = '0;
    any_pend   = 1'b0;
    pend_idx   = '0;
    any_held   = 1'b0;
    held_idx   = '0;
    hi_pend    = 1'b0;
    other_wait = 1'b0;
    for (int i = NO_MASTERS - 1; i >= 0; i--) begin
      if (state_q[i] inside {ST_GRANTED, ST_COMM, ST_PREEMPTED}) begin
        bus_busy  = 1'b1;
        owner_idx = M_ID_WIDTH'(i);
      end
      if (state_q[i] == ST_PENDING) begin
        any_pend = 1'b1;
        pend_idx = M_ID_WIDTH'(i);
      end
      if (state_q[i] == ST_HELD) begin
        any_held = 1'b1;
        held_idx = M_ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NO_MASTERS; i++) begin
      if (i != int'(owner_idx) && state_q[i] inside {ST_PENDING, ST_HELD})
        other_wait = 1'b1;
      if (i < int'(owner_idx) && state_q[i] == ST_PENDING)
        hi_pend = 1'b1;
    end
    grant_vld   = !bus_busy && (any_pend || any_held);
    grant_idx   = any_pend ? pend_idx : held_idx;
    preempt_vld = bus_busy && (state_q[owner_idx] == ST_COMM) &&
                  (hi_pend || (!ready && other_wait));
  end

  always_comb begin
    bus_d  = bus_q;
    sid_nx = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rx_d[i]    = rx_q[i];
      sid_d[i]   = sid_q[i];
      tx_d[i]    = {tx_q[i][0], 1'b0};
      po_d[i]    = tx_q[i][1];
      sid_nx     = S_ID_WIDTH'({sid_q[i], port_in[i]});

      case (state_q[i])
        ST_IDLE: begin
          if (port_in[i]) begin
            state_d[i] = ST_RX_REQ;
            cnt_d[i]   = CW'(1);
          end
        end

        ST_RX_REQ: begin
          cnt_d[i] = cnt_q[i] + CW'(1);
          if (cnt_q[i] < REQ_SID_FIRST) begin
            if (!port_in[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end
          end else begin
            sid_d[i] = sid_nx;
            if (cnt_q[i] == REQ_LAST) begin
              cnt_d[i] = '0;
              if (sid_nx != '0 && int'(sid_nx) <= NO_SLAVES)
                state_d[i] = ST_PENDING;
              else
                state_d[i] = ST_IDLE;
            end
          end
        end

        ST_PENDING, ST_HELD: begin
          if (grant_vld && grant_idx == M_ID_WIDTH'(i)) begin
            state_d[i] = ST_GRANTED;
            cnt_d[i]   = '0;
            po_d[i]    = FRAME_GRANT[2];
            tx_d[i]    = FRAME_GRANT[1:0];
          end
        end

        ST_GRANTED: begin
          if (cnt_q[i] == '0) begin
            if (port_in[i]) cnt_d[i] = CW'(1);
          end else if (cnt_q[i] == CW'(1)) begin
            rx_d[i]  = port_in[i];
            cnt_d[i] = CW'(2);
          end else begin
            cnt_d[i] = '0;
            if ({rx_q[i], port_in[i]} == 2'b01) begin
              state_d[i] = ST_COMM;
              bus_d      = {sid_q[i], M_ID_WIDTH'(i)};
            end
          end
        end

        ST_COMM, ST_PREEMPTED: begin
          // A 0 on the held-high line opens an END (0,1,1) or HOLD (0,1,0) frame.
          if (cnt_q[i] == '0) begin
            if (!port_in[i]) cnt_d[i] = CW'(1);
          end else if (cnt_q[i] == CW'(1)) begin
            rx_d[i]  = port_in[i];
            cnt_d[i] = CW'(2);
          end else begin
            cnt_d[i] = '0;
            if ({rx_q[i], port_in[i]} == 2'b11) begin
              state_d[i] = ST_IDLE;
              bus_d      = '0;
            end else if ({rx_q[i], port_in[i]} == 2'b10) begin
              state_d[i] = ST_HELD;
              bus_d      = '0;
            end
          end
          if (state_q[i] == ST_COMM && state_d[i] == ST_COMM && preempt_vld &&
              owner_idx == M_ID_WIDTH'(i)) begin
            state_d[i] = ST_PREEMPTED;
            po_d[i]    = FRAME_PREEMPT[2];
            tx_d[i]    = FRAME_PREEMPT[1:0];
          end
        end

        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      for (int i = 0; i < NO_MASTERS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        rx_q[i]    <= 1'b0;
        sid_q[i]   <= '0;
        tx_q[i]    <= '0;
        po_q[i]    <= 1'b0;
      end
      bus_q <= '0;
    end else begin
      for (int i = 0; i < NO_MASTERS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rx_q[i]    <= rx_d[i];
        sid_q[i]   <= sid_d[i];
        tx_q[i]    <= tx_d[i];
        po_q[i]    <= po_d[i];
      end
      bus_q <= bus_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NO_MASTERS; i++) port_out[i] = po_q[i];
  end

  assign bus_state = bus_q;

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the bus arbiter: cycle-exact vector table for single-master
// transactions, then hand-written sequences for preemption, split, contention and reset.
module tb_arbiter;

  logic       clk;
  logic       rstN;
  logic       port_in  [0:1];
  logic       port_out [0:1];
  logic       ready;
  logic [2:0] bus_state;

  int n_vec;
  int n_miss;

  arbiter #(.NO_MASTERS(2), .NO_SLAVES(3)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .port_in  (port_in),
    .port_out (port_out),
    .ready    (ready),
    .bus_state(bus_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       p0;
    logic       p1;
    logic       po0;
    logic       po1;
    logic [2:0] bus;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic p0, input logic p1, input logic po0, input logic po1,
                     input logic [2:0] bus);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.po0 = po0; v.po1 = po1; v.bus = bus;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int m, input logic [7:0] bits, input int n, input logic hold);
    for (int k = n - 1; k >= 0; k--) begin
      port_in[m] = bits[k];
      tick();
    end
    port_in[m] = hold;
  endtask

  task automatic wait_frame(input int m, input logic [2:0] exp, input string name);
    logic [2:0] got;
    int t;
    t = 0;
    while (port_out[m] !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    if (t >= 30) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: no frame on port_out[%0d] within 30 cycles", name, m);
    end else begin
      got[2] = port_out[m];
      tick();
      got[1] = port_out[m];
      tick();
      got[0] = port_out[m];
      tick();
      check(name, 8'(got), 8'(exp));
      check({name, " tail"}, 8'(port_out[m]), 8'd0);
    end
  endtask

  task automatic watch_quiet(input int m, input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      seen = seen | port_out[m];
    end
    check(name, 8'(seen), 8'd0);
  endtask

  initial begin
    logic [4:0] b0, b1;
    n_vec  = 0;
    n_miss = 0;
    rstN   = 1'b1;
    ready  = 1'b1;
    port_in[0] = 1'b0;
    port_in[1] = 1'b0;

    // M1 REQUEST id=2, GRANT, START, END
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,0); add(0,0,0,0,0);
    add(0,0,0,1,0); add(0,0,0,1,0); add(0,0,0,0,0); add(0,0,0,0,0);
    add(0,1,0,0,0); add(0,0,0,0,0); add(0,1,0,0,5); add(0,1,0,0,5);
    add(0,0,0,0,5); add(0,1,0,0,5); add(0,1,0,0,0); add(0,0,0,0,0);
    // M0 REQUEST id=3, GRANT, START, END
    add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,0);
    add(0,0,1,0,0); add(0,0,1,0,0); add(0,0,0,0,0);
    add(1,0,0,0,0); add(0,0,0,0,0); add(1,0,0,0,6); add(1,0,0,0,6);
    add(0,0,0,0,6); add(1,0,0,0,6); add(1,0,0,0,0); add(0,0,0,0,0);
    // M1 REQUEST id=0 is discarded: no GRANT follows
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,0); add(0,0,0,0,0); add(0,0,0,0,0);
    add(0,0,0,0,0); add(0,0,0,0,0); add(0,0,0,0,0);

    tick(); tick();
    check("reset bus_state", 8'(bus_state), 8'd0);
    check("reset port_out", 8'({port_out[0], port_out[1]}), 8'd0);
    rstN = 1'b0;
    tick();

    for (int k = 0; k < tbl.size(); k++) begin
      port_in[0] = tbl[k].p0;
      port_in[1] = tbl[k].p1;
      tick();
      check($sformatf("vec %0d", k),
            8'({port_out[0], port_out[1], bus_state}),
            8'({tbl[k].po0, tbl[k].po1, tbl[k].bus}));
    end
    port_in[0] = 1'b0;
    port_in[1] = 1'b0;
    tick();

    // Priority preemption and re-grant of the held master
    send(1, 8'b11101, 5, 1'b0);
    wait_frame(1, 3'b110, "t3 grant m1");
    send(1, 8'b101, 3, 1'b1);
    check("t3 bus m1", 8'(bus_state), 8'd3);
    send(0, 8'b11101, 5, 1'b0);
    wait_frame(1, 3'b101, "t3 preempt m1");
    check("t3 m1 still owns", 8'(bus_state), 8'd3);
    check("t3 no grant m0 yet", 8'(port_out[0]), 8'd0);
    send(1, 8'b010, 3, 1'b0);
    check("t3 bus free after hold", 8'(bus_state), 8'd0);
    wait_frame(0, 3'b110, "t3 grant m0");
    send(0, 8'b101, 3, 1'b1);
    check("t3 bus m0", 8'(bus_state), 8'd2);
    send(0, 8'b011, 3, 1'b0);
    check("t3 bus after m0 end", 8'(bus_state), 8'd0);
    wait_frame(1, 3'b110, "t3 regrant m1");
    send(1, 8'b101, 3, 1'b1);
    check("t3 bus m1 resumed", 8'(bus_state), 8'd3);
    send(1, 8'b011, 3, 1'b0);
    check("t3 bus after m1 end", 8'(bus_state), 8'd0);

    // Split for a stalled slave
    send(0, 8'b11110, 5, 1'b0);
    wait_frame(0, 3'b110, "t4 grant m0");
    send(0, 8'b101, 3, 1'b1);
    check("t4 bus m0", 8'(bus_state), 8'd4);
    ready = 1'b0;
    watch_quiet(0, 3, "t4 no split without waiter");
    send(1, 8'b11111, 5, 1'b0);
    wait_frame(0, 3'b101, "t4 split m0");
    send(0, 8'b010, 3, 1'b0);
    check("t4 bus free after hold", 8'(bus_state), 8'd0);
    ready = 1'b1;
    wait_frame(1, 3'b110, "t4 grant m1 before held m0");
    send(1, 8'b101, 3, 1'b1);
    check("t4 bus m1", 8'(bus_state), 8'd7);
    send(1, 8'b011, 3, 1'b0);
    check("t4 bus after m1 end", 8'(bus_state), 8'd0);
    wait_frame(0, 3'b110, "t4 regrant m0");
    send(0, 8'b101, 3, 1'b1);
    check("t4 bus m0 resumed", 8'(bus_state), 8'd4);
    send(0, 8'b011, 3, 1'b0);
    check("t4 bus after m0 end", 8'(bus_state), 8'd0);

    // Simultaneous requests: M0 id=1, M1 id=2
    b0 = 5'b11101;
    b1 = 5'b11110;
    for (int k = 4; k >= 0; k--) begin
      port_in[0] = b0[k];
      port_in[1] = b1[k];
      tick();
    end
    port_in[0] = 1'b0;
    port_in[1] = 1'b0;
    wait_frame(0, 3'b110, "t5 grant m0 first");
    check("t5 m1 not granted", 8'(port_out[1]), 8'd0);
    send(0, 8'b101, 3, 1'b1);
    check("t5 bus m0", 8'(bus_state), 8'd2);
    watch_quiet(1, 4, "t5 m1 waits during m0 comm");
    check("t5 no preempt of m0", 8'(port_out[0]), 8'd0);
    send(0, 8'b011, 3, 1'b0);
    check("t5 bus after m0 end", 8'(bus_state), 8'd0);
    wait_frame(1, 3'b110, "t5 grant m1 after m0 end");
    send(1, 8'b101, 3, 1'b1);
    check("t5 bus m1", 8'(bus_state), 8'd5);
    send(1, 8'b011, 3, 1'b0);
    check("t5 bus after m1 end", 8'(bus_state), 8'd0);

    // Asynchronous reset in the middle of M1 COMM and a partial M0 request
    send(1, 8'b11111, 5, 1'b0);
    wait_frame(1, 3'b110, "t6 grant m1");
    send(1, 8'b101, 3, 1'b1);
    check("t6 bus m1", 8'(bus_state), 8'd7);
    send(0, 8'b111, 3, 1'b1);
    #2;
    rstN = 1'b1;
    #1;
    check("t6 async reset bus", 8'(bus_state), 8'd0);
    check("t6 async reset port_out", 8'({port_out[0], port_out[1]}), 8'd0);
    port_in[0] = 1'b0;
    port_in[1] = 1'b0;
    tick();
    tick();
    rstN = 1'b0;
    tick();
    send(0, 8'b11101, 5, 1'b0);
    wait_frame(0, 3'b110, "t6 grant after reset");
    send(0, 8'b101, 3, 1'b1);
    check("t6 bus m0 after reset", 8'(bus_state), 8'd2);
    send(0, 8'b011, 3, 1'b0);
    check("t6 bus after end", 8'(bus_state), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
